// File: rtl/timer.sv
// timer: memory-mapped DIV/TIMA/TMA/TAC timer with a delayed TMA reload and
// a one-cycle interrupt request pulse. One clk is one T-cycle.
// Build option: define TIMER_GLITCH_EN to let DIV/TAC writes that pull the
// selected tap from 1 to 0 clock TIMA, as the original DMG silicon does.
module timer #(
  parameter logic [15:0] BASE = 16'hFF04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  input  logic        rd_enable,
  input  logic        wr_enable,
  output logic        hit,
  output logic        int_timer
);

  typedef enum logic {IDLE, RELOAD} state_t;

  logic [15:0] div_cnt_reg;
  logic [7:0]  tima_reg;
  logic [7:0]  tma_reg;
  logic [2:0]  tac_reg;
  logic        sel_q_reg;
  state_t      state_reg;
  logic [1:0]  delay_reg;
  logic        int_timer_reg;

  logic [15:0] offset;
  logic [3:0]  wr_sel;
  logic [15:0] div_cnt_next;
  logic [2:0]  tac_next;
  logic [3:0]  taps_now;
  logic        sel;
  logic        sel_q_next;
  logic        inc;

  // Offset from BASE; any address within the 4-byte window is ours.
  assign offset = addr - BASE;
  assign hit    = (offset[15:2] == 14'd0);

  // One write strobe per register in the window.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_wr_sel
      assign wr_sel[gi] = wr_enable & hit & (offset[1:0] == 2'(gi));
    end
  endgenerate

  // Values the divider and TAC will hold after this edge.
  assign div_cnt_next = wr_sel[0] ? 16'h0000 : div_cnt_reg + 16'd1;
  assign tac_next     = wr_sel[3] ? data_in[2:0] : tac_reg;

  // Tap order follows the TAC[1:0] encoding: 00->bit9, 01->bit3, 10->bit5, 11->bit7.
  assign taps_now = {div_cnt_reg[7], div_cnt_reg[5], div_cnt_reg[3], div_cnt_reg[9]};
  assign sel      = taps_now[tac_reg[1:0]] & tac_reg[2];
  assign inc      = sel_q_reg & ~sel;

`ifdef TIMER_GLITCH_EN
  // Edge detector always tracks the true previous sel, so bus writes can clock TIMA.
  assign sel_q_next = sel;
`else
  logic [3:0] taps_post;
  logic       sel_post;

  // On DIV/TAC writes, prime the edge detector with the post-write sel so only
  // free-running divider edges ever clock TIMA.
  assign taps_post  = {div_cnt_next[7], div_cnt_next[5], div_cnt_next[3], div_cnt_next[9]};
  assign sel_post   = taps_post[tac_next[1:0]] & tac_next[2];
  assign sel_q_next = (wr_sel[0] | wr_sel[3]) ? sel_post : sel;
`endif

  // Combinational read mux; idle bus reads as zero.
  always_comb begin
    data_out = 8'h00;
    if (hit && rd_enable) begin
      case (offset[1:0])
        2'd0:    data_out = div_cnt_reg[15:8];
        2'd1:    data_out = tima_reg;
        2'd2:    data_out = tma_reg;
        default: data_out = {5'b11111, tac_reg};
      endcase
    end
  end

  // Divider, registers and the overflow/reload FSM with its registered interrupt.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_reg   <= 16'h0000;
      tima_reg      <= 8'h00;
      tma_reg       <= 8'h00;
      tac_reg       <= 3'b000;
      sel_q_reg     <= 1'b0;
      state_reg     <= IDLE;
      delay_reg     <= 2'd0;
      int_timer_reg <= 1'b0;
    end else begin
      div_cnt_reg   <= div_cnt_next;
      tac_reg       <= tac_next;
      sel_q_reg     <= sel_q_next;
      int_timer_reg <= 1'b0;
      if (wr_sel[2]) begin
        tma_reg <= data_in;
      end
      if (state_reg == RELOAD && delay_reg == 2'd0) begin
        // Reload cycle: TMA (including one written right now) beats any TIMA write.
        tima_reg      <= wr_sel[2] ? data_in : tma_reg;
        int_timer_reg <= 1'b1;
        state_reg     <= IDLE;
      end else if (wr_sel[1]) begin
        // A TIMA write beats an increment and cancels a pending reload.
        tima_reg  <= data_in;
        state_reg <= IDLE;
      end else begin
        if (state_reg == RELOAD) begin
          delay_reg <= delay_reg - 2'd1;
        end
        if (inc) begin
          if (state_reg == IDLE && tima_reg == 8'hFF) begin
            tima_reg  <= 8'h00;
            state_reg <= RELOAD;
            delay_reg <= 2'd3;
          end else begin
            tima_reg <= tima_reg + 8'd1;
          end
        end
      end
    end
  end

  assign int_timer = int_timer_reg;

endmodule

// File: tb/tb_timer.sv
// tb_timer: directed scenarios plus a randomized run against a cycle-indexed
// behavioural model of the timer.
module tb_timer;

  localparam logic [15:0] BASE = 16'hFF04;

`ifdef TIMER_GLITCH_EN
  localparam bit GLITCH = 1'b1;
`else
  localparam bit GLITCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        rd_enable;
  logic        wr_enable;
  logic        hit;
  logic        int_timer;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model state; reloads are scheduled by absolute edge number.
  int unsigned m_div, m_tima, m_tma, m_tac;
  bit          m_selq, m_irq;
  longint      edge_no     = 0;
  longint      reload_edge = -1;
  int          tap_pos[4]  = '{9, 3, 5, 7};

  always #5 clk = ~clk;

  timer #(.BASE(BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .data_in   (data_in),
    .data_out  (data_out),
    .rd_enable (rd_enable),
    .wr_enable (wr_enable),
    .hit       (hit),
    .int_timer (int_timer)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic bit m_sel(int unsigned d, int unsigned t);
    return (((d >> tap_pos[t % 4]) & 1) == 1) && ((t & 4) != 0);
  endfunction

  function automatic int unsigned m_read(int unsigned a, bit rd);
    if (!rd || a < BASE || a > BASE + 3) return 0;
    case (a - BASE)
      0:       return m_div >> 8;
      1:       return m_tima;
      2:       return m_tma;
      default: return 32'hF8 | m_tac;
    endcase
  endfunction

  // Advance the model by one edge using the current inputs, then the DUT.
  task automatic cycle();
    int          off;
    bit          sel_now, fall;
    int unsigned nd, nt, ntma, ntima;
    edge_no++;
    if (rst) begin
      m_div = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_selq = 0; m_irq = 0; reload_edge = -1;
    end else begin
      off = -1;
      if (wr_enable && addr >= BASE && addr <= BASE + 16'd3) off = int'(addr - BASE);
      sel_now = m_sel(m_div, m_tac);
      fall    = m_selq && !sel_now;
      nd      = (off == 0) ? 0 : ((m_div + 1) & 16'hFFFF);
      nt      = (off == 3) ? (data_in & 7) : m_tac;
      ntma    = (off == 2) ? data_in : m_tma;
      ntima   = m_tima;
      m_irq   = 0;
      if (reload_edge == edge_no) begin
        ntima = ntma; m_irq = 1; reload_edge = -1;
      end else if (off == 1) begin
        ntima = data_in; reload_edge = -1;
      end else if (fall) begin
        if (m_tima == 255) begin
          ntima = 0;
          if (reload_edge < 0) reload_edge = edge_no + 4;
        end else begin
          ntima = m_tima + 1;
        end
      end
      if (GLITCH) m_selq = sel_now;
      else        m_selq = (off == 0 || off == 3) ? m_sel(nd, nt) : sel_now;
      m_div = nd; m_tac = nt; m_tma = ntma; m_tima = ntima;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    wr_enable = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic bus_write(int unsigned off, int unsigned d);
    addr = BASE + 16'(off); data_in = 8'(d); wr_enable = 1'b1; rd_enable = 1'b0;
    $display("[TB] write off=%0d data=%02h edge=%0d", off, d & 255, edge_no + 1);
    cycle();
    wr_enable = 1'b0;
  endtask

  task automatic read_reg(int unsigned off);
    addr = BASE + 16'(off); rd_enable = 1'b1; wr_enable = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_enable = 1'b0; rd_enable = 1'b0; addr = 16'h0000; data_in = 8'h00;
    cycle(); cycle();
    rst = 1'b0;
  endtask

  // Leaves TIMA at the wrap edge (tima just became 00) of an FF->00 overflow with TMA=AB.
  task automatic setup_overflow(output bit found);
    do_reset();
    bus_write(2, 8'hAB);
    bus_write(1, 8'hFF);
    bus_write(3, 8'h05);
    found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      idle(1);
      read_reg(1);
      if (data_out === 8'h00) found = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    bit         exp_hit;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      read_reg(i);
      exp = (i == 3) ? 8'hF8 : 8'h00;
      n_tests++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL reset_read off=%0d got=%02h exp=%02h", i, data_out, exp);
      end
    end
    for (int a = 16'hFF03; a <= 16'hFF08; a++) begin
      addr = 16'(a); rd_enable = 1'b1; #1;
      exp_hit = (a >= 16'hFF04 && a <= 16'hFF07);
      n_tests++;
      if (hit !== exp_hit) begin
        n_fail++; $display("FAIL reset_hit addr=%04h got=%b exp=%b", a, hit, exp_hit);
      end
      if (!exp_hit) begin
        n_tests++;
        if (data_out !== 8'h00) begin
          n_fail++; $display("FAIL miss_data addr=%04h got=%02h exp=00", a, data_out);
        end
      end
    end
    addr = BASE + 16'd3; rd_enable = 1'b0; #1;
    n_tests++;
    if (data_out !== 8'h00) begin
      n_fail++; $display("FAIL no_rd_data got=%02h exp=00", data_out);
    end
    n_tests++;
    if (int_timer !== 1'b0) begin
      n_fail++; $display("FAIL reset_int got=%b exp=0", int_timer);
    end
  endtask

  task automatic test_count();
    do_reset();
    bus_write(3, 8'h05);
    idle(15);
    read_reg(1);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL count_e16 got=%02h exp=00", data_out); end
    idle(1);
    read_reg(1);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL count_e17 got=%02h exp=01", data_out); end
    idle(239);
    read_reg(0);
    n_tests++;
    if (data_out !== 8'h01) begin n_fail++; $display("FAIL div_256 got=%02h exp=01", data_out); end
    read_reg(1);
    n_tests++;
    if (data_out !== 8'h0F) begin n_fail++; $display("FAIL count_e256 got=%02h exp=0F", data_out); end
    idle(1);
    read_reg(1);
    n_tests++;
    if (data_out !== 8'h10) begin n_fail++; $display("FAIL count_e257 got=%02h exp=10", data_out); end
  endtask

  task automatic test_overflow();
    bit found;
    logic [7:0] exp;
    setup_overflow(found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL ovf_wrap_timeout got=no_wrap exp=wrap"); end
    for (int k = 1; k <= 5; k++) begin
      idle(1);
      read_reg(1);
      exp = (k < 4) ? 8'h00 : 8'hAB;
      n_tests++;
      if (data_out !== exp) begin
        n_fail++; $display("FAIL ovf_tima k=%0d got=%02h exp=%02h", k, data_out, exp);
      end
      n_tests++;
      if (int_timer !== (k == 4)) begin
        n_fail++; $display("FAIL ovf_int k=%0d got=%b exp=%b", k, int_timer, k == 4);
      end
    end
  endtask

  task automatic test_cancel();
    bit found;
    setup_overflow(found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL cancel_wrap_timeout got=no_wrap exp=wrap"); end
    idle(1);
    bus_write(1, 8'h42);
    for (int k = 0; k < 6; k++) begin
      read_reg(1);
      n_tests++;
      if (data_out !== 8'h42 || int_timer !== 1'b0) begin
        n_fail++;
        $display("FAIL cancel k=%0d got tima=%02h int=%b exp tima=42 int=0", k, data_out, int_timer);
      end
      idle(1);
    end
  endtask

  task automatic test_tma_reload();
    bit found;
    setup_overflow(found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL tma_wrap_timeout got=no_wrap exp=wrap"); end
    idle(3);
    bus_write(2, 8'h77);
    read_reg(1);
    n_tests++;
    if (data_out !== 8'h77 || int_timer !== 1'b1) begin
      n_fail++; $display("FAIL tma_on_reload got tima=%02h int=%b exp tima=77 int=1", data_out, int_timer);
    end
    idle(1);
    n_tests++;
    if (int_timer !== 1'b0) begin n_fail++; $display("FAIL tma_pulse_len got=%b exp=0", int_timer); end
    setup_overflow(found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL tima_wrap_timeout got=no_wrap exp=wrap"); end
    idle(3);
    bus_write(1, 8'h55);
    read_reg(1);
    n_tests++;
    if (data_out !== 8'hAB || int_timer !== 1'b1) begin
      n_fail++; $display("FAIL tima_on_reload got tima=%02h int=%b exp tima=AB int=1", data_out, int_timer);
    end
  endtask

  task automatic test_reset_reload();
    bit found;
    setup_overflow(found);
    n_tests++;
    if (!found) begin n_fail++; $display("FAIL rstrl_wrap_timeout got=no_wrap exp=wrap"); end
    idle(1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      read_reg(1);
      n_tests++;
      if (int_timer !== 1'b0 || data_out !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_reload k=%0d got int=%b tima=%02h exp int=0 tima=00", k, int_timer, data_out);
      end
      idle(1);
    end
  endtask

  task automatic test_glitch();
    logic [7:0] exp;
    exp = GLITCH ? 8'h01 : 8'h00;
    // DIV write while the bit-3 tap is high.
    do_reset();
    bus_write(3, 8'h05);
    idle(7);
    bus_write(0, 8'h99);
    idle(1);
    read_reg(1);
    n_tests++;
    if (data_out !== exp) begin n_fail++; $display("FAIL glitch_div got=%02h exp=%02h", data_out, exp); end
    read_reg(0);
    n_tests++;
    if (data_out !== 8'h00) begin n_fail++; $display("FAIL div_clear got=%02h exp=00", data_out); end
    idle(5);
    read_reg(1);
    n_tests++;
    if (data_out !== exp) begin n_fail++; $display("FAIL glitch_div_hold got=%02h exp=%02h", data_out, exp); end
    // TAC disable while the tap is high.
    do_reset();
    bus_write(3, 8'h05);
    idle(7);
    bus_write(3, 8'h00);
    idle(1);
    read_reg(1);
    n_tests++;
    if (data_out !== exp) begin n_fail++; $display("FAIL glitch_tac_off got=%02h exp=%02h", data_out, exp); end
    // TAC tap change (bit3 high -> bit5 low).
    do_reset();
    bus_write(3, 8'h05);
    idle(7);
    bus_write(3, 8'h06);
    idle(1);
    read_reg(1);
    n_tests++;
    if (data_out !== exp) begin n_fail++; $display("FAIL glitch_tac_tap got=%02h exp=%02h", data_out, exp); end
  endtask

  task automatic test_random();
    int unsigned r, off, d, a;
    bit          rd;
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      r = $urandom_range(0, 15);
      if (r < 2) begin
        off = $urandom_range(0, 3);
        d   = $urandom_range(0, 255);
        if (off == 1 && $urandom_range(0, 1) == 1) d = $urandom_range(8'hF0, 8'hFF);
        if (off == 3 && $urandom_range(0, 3) != 0) d = d | 4;
        bus_write(off, d);
      end else if (r == 15 && $urandom_range(0, 40) == 0) begin
        rst = 1'b1; wr_enable = 1'b0;
        cycle();
        rst = 1'b0;
      end else begin
        idle(1);
      end
      n_tests++;
      if (int_timer !== m_irq) begin
        n_fail++; $display("FAIL rand_int it=%0d got=%b exp=%b", it, int_timer, m_irq);
      end
      a  = BASE - 1 + $urandom_range(0, 5);
      rd = ($urandom_range(0, 7) != 0);
      addr = 16'(a); rd_enable = rd; wr_enable = 1'b0;
      #1;
      n_tests++;
      if (data_out !== 8'(m_read(a, rd)) || hit !== (a >= BASE && a <= BASE + 3)) begin
        n_fail++;
        $display("FAIL rand_read it=%0d addr=%04h rd=%b got data=%02h hit=%b exp data=%02h",
                 it, a, rd, data_out, hit, m_read(a, rd));
      end
    end
  endtask

  initial begin
    rst = 1'b1; addr = 16'h0000; data_in = 8'h00; rd_enable = 1'b0; wr_enable = 1'b0;
    test_reset();
    test_count();
    test_overflow();
    test_cancel();
    test_tma_reload();
    test_reset_reload();
    test_glitch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
